// File: rtl/busy_stall_injector.sv
// busy_stall_injector: drives the SoC busy/stall input with LFSR-chosen busy
// levels, each held for a pseudo-random number of cycles, and keeps
// saturating statistics counters for stall-stress and throughput measurement.
module busy_stall_injector #(
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter int          HOLD_MIN = 5,
    parameter int          HOLD_MAX = 10,
    parameter int          CNT_W    = 64
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             en,
    input  logic [6:0]       prob_pct,
    input  logic             clr,
    output logic             busy,
    output logic [CNT_W-1:0] busy_cycles,
    output logic [CNT_W-1:0] run_cycles,
    output logic [CNT_W-1:0] seg_count
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [7:0]  HOLD_BASE = 8'(HOLD_MIN);
    localparam logic [15:0] HOLD_SPAN = 16'(HOLD_MAX - HOLD_MIN + 1);

    typedef enum logic {ST_OFF, ST_RUN} state_t;

    state_t           r_state, w_state_nxt;
    logic             r_busy, w_busy_nxt;
    logic [15:0]      r_lfsr, w_lfsr_nxt;
    logic [7:0]       r_hold_cnt, w_hold_nxt;
    logic [CNT_W-1:0] r_busy_cycles, r_run_cycles, r_seg_count;

    logic [7:0]       w_r;
    logic [7:0]       w_hold;
    logic [6:0]       w_prob;
    logic             w_busy_dec;
    logic [15:0]      w_lfsr_adv;
    logic             w_decide;

    // Decision inputs come from the LFSR value before it advances.
    assign w_r        = 8'((16'(r_lfsr[15:8]) * 16'd100) >> 8);
    assign w_hold     = HOLD_BASE + 8'((16'(r_lfsr[7:0]) * HOLD_SPAN) >> 8);
    assign w_prob     = (prob_pct > 7'd100) ? 7'd100 : prob_pct;
    assign w_busy_dec = (w_r < {1'b0, w_prob});
    assign w_lfsr_adv = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_MASK) : (r_lfsr >> 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Next-state: decide on entry to RUN and whenever the hold count runs out.
    always_comb begin
        w_state_nxt = r_state;
        w_busy_nxt  = r_busy;
        w_hold_nxt  = r_hold_cnt;
        w_lfsr_nxt  = r_lfsr;
        w_decide    = 1'b0;
        case (r_state)
            ST_OFF: begin
                w_busy_nxt = 1'b0;
                if (en) w_decide = 1'b1;
            end
            ST_RUN: begin
                if (!en) begin
                    w_busy_nxt  = 1'b0;
                    w_hold_nxt  = 8'd0;
                    w_state_nxt = ST_OFF;
                end else if (r_hold_cnt != 8'd0) begin
                    w_hold_nxt = r_hold_cnt - 8'd1;
                end else begin
                    w_decide = 1'b1;
                end
            end
            default: w_state_nxt = ST_OFF;
        endcase
        if (w_decide) begin
            w_busy_nxt  = w_busy_dec;
            w_hold_nxt  = w_hold;
            w_lfsr_nxt  = w_lfsr_adv;
            w_state_nxt = ST_RUN;
        end
    end

    // FSM, busy level, hold counter and LFSR registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state    <= ST_OFF;
            r_busy     <= 1'b0;
            r_lfsr     <= LFSR_INIT;
            r_hold_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= w_busy_nxt;
            r_lfsr     <= w_lfsr_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    // Saturating statistics; clr beats any increment in the same cycle.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_busy_cycles <= '0;
            r_run_cycles  <= '0;
            r_seg_count   <= '0;
        end else if (clr) begin
            r_busy_cycles <= '0;
            r_run_cycles  <= '0;
            r_seg_count   <= '0;
        end else begin
            if (r_state == ST_RUN) begin
                r_run_cycles <= sat_inc(r_run_cycles);
                if (r_busy) r_busy_cycles <= sat_inc(r_busy_cycles);
            end
            if (w_decide) r_seg_count <= sat_inc(r_seg_count);
        end
    end

    assign busy        = r_busy;
    assign busy_cycles = r_busy_cycles;
    assign run_cycles  = r_run_cycles;
    assign seg_count   = r_seg_count;

endmodule

// File: tb/tb_busy_stall_injector.sv
// Bench for busy_stall_injector: hand-derived vector table, reset/hold
// sequences, then long runs against a segment-queue reference model.
module tb_busy_stall_injector;

    localparam int HMIN = 5;
    localparam int HMAX = 10;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        en = 1'b0;
    logic [6:0]  prob_pct = 7'd0;
    logic        clr = 1'b0;
    logic        busy, busy4;
    logic [63:0] busy_cycles, run_cycles, seg_count;
    logic [3:0]  busy_cycles4, run_cycles4, seg_count4;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    busy_stall_injector dut (
        .clk(clk), .rstN(rstN), .en(en), .prob_pct(prob_pct), .clr(clr),
        .busy(busy), .busy_cycles(busy_cycles), .run_cycles(run_cycles),
        .seg_count(seg_count)
    );

    busy_stall_injector #(.CNT_W(4)) dut4 (
        .clk(clk), .rstN(rstN), .en(en), .prob_pct(prob_pct), .clr(clr),
        .busy(busy4), .busy_cycles(busy_cycles4), .run_cycles(run_cycles4),
        .seg_count(seg_count4)
    );

    // Reference model: each decision pushes the whole segment's busy levels
    // into a queue; every enabled cycle consumes one entry.
    logic [15:0]     m_lfsr;
    bit              m_q[$];
    bit              m_run, m_busy;
    longint unsigned m_bc, m_rc, m_sc;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic longint unsigned sat4(input longint unsigned v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic model_reset();
        m_lfsr = 16'hACE1;
        m_q.delete();
        m_run = 0; m_busy = 0;
        m_bc = 0; m_rc = 0; m_sc = 0;
    endtask

    task automatic model_edge(input bit en_i, input int prob_i, input bit clr_i);
        int r, h, p;
        bit lvl;
        if (m_run) begin
            m_rc++;
            if (m_busy) m_bc++;
        end
        if (!en_i) begin
            m_q.delete();
            m_run = 0;
            m_busy = 0;
        end else begin
            if (m_q.size() == 0) begin
                r   = (int'(m_lfsr[15:8]) * 100) / 256;
                h   = HMIN + (int'(m_lfsr[7:0]) * (HMAX - HMIN + 1)) / 256;
                p   = (prob_i > 100) ? 100 : prob_i;
                lvl = (r < p);
                for (int i = 0; i <= h; i++) m_q.push_back(lvl);
                m_lfsr = lfsr_next(m_lfsr);
                m_sc++;
            end
            m_busy = m_q.pop_front();
            m_run  = 1;
        end
        if (clr_i) begin
            m_bc = 0; m_rc = 0; m_sc = 0;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, step the model at the edge, sample 1 unit later.
    task automatic cyc(input bit en_i, input int prob_i, input bit clr_i, input bit cmp);
        en = en_i;
        prob_pct = 7'(prob_i);
        clr = clr_i;
        @(posedge clk);
        model_edge(en_i, prob_i, clr_i);
        #1;
        if (cmp) begin
            check("busy", {63'd0, busy}, {63'd0, m_busy});
            check("busy_cycles", busy_cycles, m_bc);
            check("run_cycles", run_cycles, m_rc);
            check("seg_count", seg_count, m_sc);
            check("busy_w4", {63'd0, busy4}, {63'd0, m_busy});
            check("busy_cycles_w4", {60'd0, busy_cycles4}, sat4(m_bc));
            check("run_cycles_w4", {60'd0, run_cycles4}, sat4(m_rc));
            check("seg_count_w4", {60'd0, seg_count4}, sat4(m_sc));
        end
    endtask

    task automatic do_reset();
        en = 1'b0; clr = 1'b0;
        rstN = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3 rstN = 1'b1;
    endtask

    typedef struct {
        bit              en;
        int              prob;
        bit              clr;
        bit              busy;
        longint unsigned run;
        longint unsigned bc;
        longint unsigned seg;
    } vec_t;

    vec_t tv[10];

    initial begin
        int ncyc;
        bit ok;

        // Decisions from SEED 0xACE1: r=67 hold=10, then lfsr 0xE270: r=88 hold=7.
        tv[0] = '{0, 68, 0, 0, 0, 0, 0};
        tv[1] = '{1, 68, 0, 1, 0, 0, 1};  // 67 < 68 -> busy
        tv[2] = '{1, 0,  0, 1, 1, 1, 1};  // prob change mid-segment ignored
        tv[3] = '{1, 0,  1, 1, 0, 0, 0};  // clr wins, busy unaffected
        tv[4] = '{1, 0,  0, 1, 1, 1, 0};
        tv[5] = '{0, 0,  0, 0, 2, 2, 0};  // en drop: busy falls, last RUN counted
        tv[6] = '{0, 0,  0, 0, 2, 2, 0};
        tv[7] = '{1, 88, 0, 0, 2, 2, 1};  // r == prob -> not busy
        tv[8] = '{1, 0,  0, 0, 3, 2, 1};
        tv[9] = '{0, 0,  0, 0, 4, 2, 1};

        rstN = 1'b0;
        #2;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_busy_cycles", busy_cycles, 64'd0);
        check("rst_run_cycles", run_cycles, 64'd0);
        check("rst_seg_count", seg_count, 64'd0);
        do_reset();

        for (int i = 0; i < 10; i++) begin
            cyc(tv[i].en, tv[i].prob, tv[i].clr, 1'b0);
            check($sformatf("tv%0d_busy", i), {63'd0, busy}, {63'd0, tv[i].busy});
            check($sformatf("tv%0d_run", i), run_cycles, tv[i].run);
            check($sformatf("tv%0d_bc", i), busy_cycles, tv[i].bc);
            check($sformatf("tv%0d_seg", i), seg_count, tv[i].seg);
        end

        // Async reset in the middle of a busy segment.
        repeat (3) cyc(1, 100, 0, 1'b0);
        check("pre_rst_busy", {63'd0, busy}, 64'd1);
        #2 rstN = 1'b0;
        #1;
        check("async_rst_busy", {63'd0, busy}, 64'd0);
        check("async_rst_seg", seg_count, 64'd0);
        check("async_rst_run", run_cycles, 64'd0);
        prob_pct = 7'd68;
        @(posedge clk);
        #3 rstN = 1'b1;

        // Restart must replay the first segment: 11 busy cycles, then r=88 -> idle.
        for (int k = 0; k < 12; k++) begin
            cyc(1, 68, 0, 1'b0);
            check($sformatf("restart_busy_%0d", k), {63'd0, busy}, (k < 11) ? 64'd1 : 64'd0);
        end

        // prob 0 for 1000 cycles.
        do_reset();
        for (int k = 0; k < 1000; k++) cyc(1, 0, 0, 1'b1);
        check("p0_busy_cycles", busy_cycles, 64'd0);
        check("p0_run_cycles", run_cycles, 64'd999);

        // prob 100 then 127: always busy; 4-bit counters saturate.
        for (int k = 0; k < 200; k++) cyc(1, 100, 0, 1'b1);
        for (int k = 0; k < 200; k++) cyc(1, 127, 0, 1'b1);
        check("sat_w4_run", {60'd0, run_cycles4}, 64'd15);

        // Clear on a busy cycle, then 2000 segments at 30 percent.
        cyc(1, 30, 1, 1'b1);
        ncyc = 0;
        while (m_sc < 2000 && ncyc < 40000) begin
            cyc(1, 30, 0, 1'b1);
            ncyc++;
        end
        check("p30_seg_reached", {63'd0, (m_sc >= 2000)}, 64'd1);
        ok = (busy_cycles * 100 >= run_cycles * 25) && (busy_cycles * 100 <= run_cycles * 35);
        check("p30_ratio_in_range", {63'd0, ok}, 64'd1);

        // Random enable, probability and clear.
        for (int k = 0; k < 3000; k++)
            cyc($urandom_range(0, 15) != 0, $urandom_range(0, 127), $urandom_range(0, 63) == 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
